demux4_stream: RTL and testbench
================================

DEMUX4_STREAM -- requirements
Module: demux4_stream

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, data width of the input and of each output channel.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: mode  input  1  0 = explicit steering by in_sel, 1 = round-robin steering.
REQ-005 SHALL have port: in_valid  input  1  input beat present.
REQ-006 SHALL have port: in_ready  output  1  input beat accepted this cycle when high with in_valid.
REQ-007 SHALL have port: in_sel  input  2  destination channel when mode=0.
REQ-008 SHALL have port: in_data  input  WIDTH  input payload.
REQ-009 SHALL have ports: out_valid  output  4  per-channel beat present (bit n = channel n).
REQ-010 SHALL have ports: out_ready  input  4  per-channel consumer ready.
REQ-011 SHALL have ports: out_data0..out_data3  output  WIDTH each  per-channel payload.
REQ-012 SHALL have port: rr_ptr  output  2  current round-robin destination.
REQ-013 SHALL have port: accept_cnt  output  8  count of accepted input beats.

Function
REQ-014 SHALL compute target = rr_ptr when mode=1, else in_sel; the mode change takes effect in the same cycle.
REQ-015 SHALL give each channel one single-entry output slot (valid bit plus WIDTH data register).
REQ-016 SHALL drive in_ready = !out_valid[target] | out_ready[target]; in_ready SHALL NOT depend on in_valid.
REQ-017 SHALL, on accept (in_valid & in_ready), load in_data into slot[target]; the slot SHALL be valid on the next cycle (latency 1).
REQ-018 SHALL clear a slot's valid on out_valid[n] & out_ready[n] unless the same slot loads in that cycle.
REQ-019 SHALL, on simultaneous drain and load of one slot, keep the slot valid and present the new data next cycle, with no bubble.
REQ-020 SHALL hold out_dataN stable while out_valid[n] & !out_ready[n].
REQ-021 SHALL leave untargeted slots unaffected by input activity; channels drain independently.
REQ-022 SHALL increment rr_ptr modulo 4 (3 -> 0) on each accept while mode=1; it SHALL hold otherwise, including while mode=0.
REQ-023 SHALL increment accept_cnt on every accept in either mode, wrapping 255 -> 0.
REQ-024 SHALL ignore in_sel while mode=1 and ignore in_data/in_sel while in_valid=0.

Reset
REQ-025 SHALL, while rst=1, force out_valid=4'b0000, out_data0..3=0, rr_ptr=0 and accept_cnt=0, asynchronously.
REQ-026 SHALL discard buffered beats when reset is asserted mid-operation; in_ready reads 1 during reset.
REQ-027 SHALL accept no beat in a cycle whose rising edge occurs with rst=1.

Structure
REQ-028 SHALL place NCH=4, the channel-index typedef (2 bit) and the mode enum (MODE_SEL, MODE_RR) in package demux4_pkg.
REQ-029 SHALL implement each output slot as sub-module demux4_slot (load, drain, valid, data), instantiated four times.
REQ-030 SHALL keep rr_ptr and accept_cnt in the top level.

Verification
REQ-031 SHALL cover: mode=0, out_ready=4'b0000, send A,B,C,D with in_sel 0,1,2,3 -> out_valid=4'b1111, out_data0..3=A,B,C,D, accept_cnt=4.
REQ-032 SHALL cover: slot 2 full, out_ready[2]=0, in_sel=2 -> in_ready=0 and data held; switch in_sel=1 -> in_ready=1 and beat lands in channel 1.
REQ-033 SHALL cover: slot 0 holds 3, out_ready[0]=1, and 7 is sent to channel 0 in the same cycle -> next cycle out_valid[0]=1 and out_data0=7, with no idle cycle.
REQ-034 SHALL cover: mode=1, all out_ready=1, send 1,2,3,4,5 back-to-back -> channels 0,1,2,3,0 each receive in order and rr_ptr ends at 1.
REQ-035 SHALL cover: 3 slots full, assert rst for 1 cycle mid-stream -> out_valid=0, rr_ptr=0, accept_cnt=0, and the first post-reset beat lands correctly.
REQ-036 SHALL cover: 256 accepts -> accept_cnt wraps to 0.

Source files
------------

// File: rtl/demux4_pkg.sv
// Shared types for the four-way stream demultiplexer.
package demux4_pkg;

  localparam int unsigned NCH = 4;

  typedef logic [1:0] chan_t;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

endpackage

// File: rtl/demux4_slot.sv
// Single-entry output buffer: one valid bit plus one data word per channel.
module demux4_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load in the same cycle as a drain keeps the slot full, so no bubble.
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = load ? ld_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/demux4_stream.sv
// Steers an input stream to one of four buffered output channels, by explicit select or round-robin.
module demux4_stream
  import demux4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [1:0]       rr_ptr,
  output logic [7:0]       accept_cnt
);

  chan_t            rr_ptr_q, rr_ptr_d;
  logic [7:0]       accept_cnt_q, accept_cnt_d;
  chan_t            target;
  logic             accept;
  logic             rr_mode;
  logic [NCH-1:0]   load;
  logic [WIDTH-1:0] slot_data [NCH];

  // Readiness is a pure function of the target slot, never of in_valid.
  always_comb begin
    rr_mode  = (mode_e'(mode) == MODE_RR);
    target   = rr_mode ? rr_ptr_q : chan_t'(in_sel);
    in_ready = ~out_valid[target] | out_ready[target];
    accept   = in_valid & in_ready;
    load     = '0;
    load[target] = accept;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    accept_cnt_d = accept_cnt_q;
    if (accept) begin
      accept_cnt_d = accept_cnt_q + 8'd1;
      if (rr_mode) rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      accept_cnt_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      accept_cnt_q <= accept_cnt_d;
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_slot
    demux4_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[n]),
      .ld_data   (in_data),
      .out_ready (out_ready[n]),
      .out_valid (out_valid[n]),
      .out_data  (slot_data[n])
    );
  end

  assign out_data0  = slot_data[0];
  assign out_data1  = slot_data[1];
  assign out_data2  = slot_data[2];
  assign out_data3  = slot_data[3];
  assign rr_ptr     = rr_ptr_q;
  assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_demux4_stream.sv
// Directed table-driven bench for demux4_stream plus reset and counter-wrap sequences.
module tb_demux4_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [3:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0] rr_ptr;
  logic [7:0] accept_cnt;

  int checks = 0;
  int errors = 0;

  demux4_stream #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .rr_ptr     (rr_ptr),
    .accept_cnt (accept_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mode;
    logic        vld;
    logic [1:0]  sel;
    logic [3:0]  data;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [15:0] exp_d;   // {d3,d2,d1,d0}
    logic [1:0]  exp_rr;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [15:0] all_data();
    return {out_data3, out_data2, out_data1, out_data0};
  endfunction

  initial begin
    // mode vld sel data ordy | rdy ov d rr cnt
    vecs.push_back(vec_t'{1'b0,1'b1,2'd0,4'hA,4'b0000, 1'b1,4'b0001,16'h000A,2'd0,8'd1});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd1,4'hB,4'b0000, 1'b1,4'b0011,16'h00BA,2'd0,8'd2});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd2,4'hC,4'b0000, 1'b1,4'b0111,16'h0CBA,2'd0,8'd3});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd3,4'hD,4'b0000, 1'b1,4'b1111,16'hDCBA,2'd0,8'd4});
    vecs.push_back(vec_t'{1'b0,1'b0,2'd0,4'h0,4'b0010, 1'b0,4'b1101,16'hDCBA,2'd0,8'd4});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd2,4'h5,4'b0000, 1'b0,4'b1101,16'hDCBA,2'd0,8'd4});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd1,4'h6,4'b0000, 1'b1,4'b1111,16'hDC6A,2'd0,8'd5});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd0,4'h3,4'b0001, 1'b1,4'b1111,16'hDC63,2'd0,8'd6});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd0,4'h7,4'b0001, 1'b1,4'b1111,16'hDC67,2'd0,8'd7});
    vecs.push_back(vec_t'{1'b0,1'b0,2'd0,4'h0,4'b0001, 1'b1,4'b1110,16'hDC67,2'd0,8'd7});
    vecs.push_back(vec_t'{1'b0,1'b0,2'd0,4'h0,4'b1111, 1'b1,4'b0000,16'hDC67,2'd0,8'd7});
    vecs.push_back(vec_t'{1'b1,1'b1,2'd3,4'h1,4'b1111, 1'b1,4'b0001,16'hDC61,2'd1,8'd8});
    vecs.push_back(vec_t'{1'b1,1'b1,2'd3,4'h2,4'b1111, 1'b1,4'b0010,16'hDC21,2'd2,8'd9});
    vecs.push_back(vec_t'{1'b1,1'b1,2'd3,4'h3,4'b1111, 1'b1,4'b0100,16'hD321,2'd3,8'd10});
    vecs.push_back(vec_t'{1'b1,1'b1,2'd3,4'h4,4'b1111, 1'b1,4'b1000,16'h4321,2'd0,8'd11});
    vecs.push_back(vec_t'{1'b1,1'b1,2'd3,4'h5,4'b1111, 1'b1,4'b0001,16'h4325,2'd1,8'd12});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd2,4'h9,4'b1111, 1'b1,4'b0100,16'h4925,2'd1,8'd13});
    vecs.push_back(vec_t'{1'b1,1'b0,2'd2,4'hF,4'b0000, 1'b1,4'b0100,16'h4925,2'd1,8'd13});
    vecs.push_back(vec_t'{1'b1,1'b1,2'd2,4'hE,4'b0000, 1'b1,4'b0110,16'h49E5,2'd2,8'd14});
    vecs.push_back(vec_t'{1'b1,1'b1,2'd0,4'hF,4'b0000, 1'b0,4'b0110,16'h49E5,2'd2,8'd14});
    vecs.push_back(vec_t'{1'b0,1'b1,2'd3,4'h8,4'b0000, 1'b1,4'b1110,16'h89E5,2'd2,8'd15});

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = 4'h0; out_ready = 4'b0000;
    #1;
    chk("rst_ov",   0, 32'(out_valid),  32'h0);
    chk("rst_data", 0, 32'(all_data()), 32'h0);
    chk("rst_rr",   0, 32'(rr_ptr),     32'h0);
    chk("rst_cnt",  0, 32'(accept_cnt), 32'h0);
    chk("rst_rdy",  0, 32'(in_ready),   32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      mode = vecs[i].mode; in_valid = vecs[i].vld; in_sel = vecs[i].sel;
      in_data = vecs[i].data; out_ready = vecs[i].ordy;
      #1;
      chk("in_ready", i, 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk("out_valid",  i, 32'(out_valid),  32'(vecs[i].exp_ov));
      chk("out_data",   i, 32'(all_data()), 32'(vecs[i].exp_d));
      chk("rr_ptr",     i, 32'(rr_ptr),     32'(vecs[i].exp_rr));
      chk("accept_cnt", i, 32'(accept_cnt), 32'(vecs[i].exp_cnt));
    end

    // Reset mid-stream with three slots full and a beat offered during reset.
    @(negedge clk);
    rst = 1'b1; mode = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h5; out_ready = 4'b0000;
    #1;
    chk("mid_rst_ov",   0, 32'(out_valid),  32'h0);
    chk("mid_rst_data", 0, 32'(all_data()), 32'h0);
    chk("mid_rst_rr",   0, 32'(rr_ptr),     32'h0);
    chk("mid_rst_cnt",  0, 32'(accept_cnt), 32'h0);
    chk("mid_rst_rdy",  0, 32'(in_ready),   32'h1);
    @(posedge clk);
    #1;
    chk("rst_edge_ov",  0, 32'(out_valid),  32'h0);
    chk("rst_edge_cnt", 0, 32'(accept_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0; mode = 1'b1; in_valid = 1'b1; in_sel = 2'd3; in_data = 4'h6;
    #1;
    chk("post_rst_rdy", 0, 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_ov",   0, 32'(out_valid),  32'h1);
    chk("post_rst_data", 0, 32'(all_data()), 32'h0006);
    chk("post_rst_rr",   0, 32'(rr_ptr),     32'h1);
    chk("post_rst_cnt",  0, 32'(accept_cnt), 32'h1);

    // Counter wrap: 255 more accepts in select mode take the count from 1 to 0.
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      mode = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = 4'(i); out_ready = 4'b1111;
      @(posedge clk);
      #1;
      if (i == 253) chk("cnt_255", i, 32'(accept_cnt), 32'd255);
    end
    chk("cnt_wrap",     0, 32'(accept_cnt), 32'd0);
    chk("rr_hold_sel",  0, 32'(rr_ptr),     32'd1);
    chk("wrap_last_d0", 0, 32'(out_data0),  32'hE);

    @(negedge clk);
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
